// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM behind a req/ack handshake with a
// fixed number of wait states and byte-lane writes.
// Optional feature: define DMEM_ALIGN_CHK_EN to flag misaligned byte-enable /
// address combinations with err_o (write suppressed, load data forced to 0).
// Without the macro err_o is tied low and addr_i[1:0] is ignored.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // Counter preload; irrelevant when WAIT_CYCLES is 0 (WAIT is skipped).
    localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [3:0]              cnt_reg;
    logic [3:0]              cnt_next;
    logic                    capture;

    // Operands captured at acceptance; later input changes are ignored.
    logic                    we_reg;
    logic [ADDR_WIDTH-1:0]   idx_reg;
    logic [3:0]              be_reg;
    logic [31:0]             wdata_reg;
    logic                    legal_reg;

    // Operands seen by the RAM on the edge that enters RESP. With zero wait
    // states that edge is the acceptance edge itself, so the live inputs
    // must be used instead of the (not yet loaded) capture registers.
    logic                    op_we;
    logic [ADDR_WIDTH-1:0]   op_idx;
    logic [3:0]              op_be;
    logic [31:0]             op_wdata;
    logic                    op_legal;

    logic                    in_legal;
    logic                    enter_resp;
    logic                    do_write;
    logic                    do_read;

    // Address bits that never influence the word index.
    logic                    unused_addr_bits;
    assign unused_addr_bits = &{1'b0, addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};

`ifdef DMEM_ALIGN_CHK_EN
    // Single bytes anywhere, halfwords on even addresses, words on 4-byte
    // boundaries; everything else (including be=0000) is rejected.
    function automatic logic align_ok(input logic [3:0] be, input logic [1:0] lsb);
        logic ok;
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = 1'b1;
            4'b0011, 4'b1100:                   ok = ~lsb[0];
            4'b1111:                            ok = (lsb == 2'b00);
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign in_legal = align_ok(be_i, addr_i[1:0]);
    assign err_o    = (state_reg == ST_RESP) && !legal_reg;
`else
    assign in_legal = 1'b1;
    assign err_o    = 1'b0;
`endif

    // Next-state, wait counter and handshake outputs.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        ack_o      = 1'b0;
        busy_o     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_i) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_next = ST_WAIT;
                        cnt_next   = CNT_INIT;
                    end else begin
                        state_next = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                busy_o = 1'b1;
                if (cnt_reg == 4'd0) begin
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_RESP: begin
                busy_o     = 1'b1;
                ack_o      = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // State and wait-counter registers; reset drops any in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Capture the request operands at acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_reg    <= 1'b0;
            idx_reg   <= '0;
            be_reg    <= 4'd0;
            wdata_reg <= 32'd0;
            legal_reg <= 1'b1;
        end else if (capture) begin
            we_reg    <= we_i;
            idx_reg   <= addr_i[ADDR_WIDTH+1:2];
            be_reg    <= be_i;
            wdata_reg <= wdata_i;
            legal_reg <= in_legal;
        end
    end

    // Select live inputs in IDLE (zero-wait path), captured copies otherwise.
    always_comb begin
        op_we    = we_reg;
        op_idx   = idx_reg;
        op_be    = be_reg;
        op_wdata = wdata_reg;
        op_legal = legal_reg;
        if (state_reg == ST_IDLE) begin
            op_we    = we_i;
            op_idx   = addr_i[ADDR_WIDTH+1:2];
            op_be    = be_i;
            op_wdata = wdata_i;
            op_legal = in_legal;
        end
    end

    // The RAM is accessed exactly once per transaction, on the edge into RESP.
    assign enter_resp = (state_next == ST_RESP);
    assign do_write   = enter_resp && op_we && op_legal && !rst;
    assign do_read    = enter_resp && !op_we;

    // One byte-wide RAM per lane so each lane has an independent write enable.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] q_reg;

            // Lane write, gated by its byte enable.
            always_ff @(posedge clk) begin
                if (do_write && op_be[gi]) begin
                    mem[op_idx] <= op_wdata[8*gi +: 8];
                end
            end

            // Registered lane read; holds between loads, zero for rejected loads.
            always_ff @(posedge clk) begin
                if (rst) begin
                    q_reg <= 8'd0;
                end else if (do_read) begin
                    q_reg <= op_legal ? mem[op_idx] : 8'd0;
                end
            end
        end
    endgenerate

    assign rdata_o = {g_lane[3].q_reg, g_lane[2].q_reg, g_lane[1].q_reg, g_lane[0].q_reg};

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table vectors, hand-written multi-cycle sequences and
// randomized transactions checked against a word-array reference model.
module tb_dmem_responder;

    localparam int AW    = 10;
    localparam int WC    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int PER   = WC + 2;
`ifdef DMEM_ALIGN_CHK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        ack_o;
    logic        busy_o;
    logic        err_o;

    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .be_i    (be_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o),
        .ack_o   (ack_o),
        .busy_o  (busy_o),
        .err_o   (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: memory image and the last value a load returned.
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] last_rd;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h", what, act, exp);
        end
    endtask

    function automatic bit ref_legal(input logic [3:0] be, input logic [31:0] addr);
        if (!ALIGN_EN) return 1'b1;
        if (be == 4'b0001 || be == 4'b0010 || be == 4'b0100 || be == 4'b1000) return 1'b1;
        if (be == 4'b0011 || be == 4'b1100) return (addr % 2) == 0;
        if (be == 4'b1111) return (addr % 4) == 0;
        return 1'b0;
    endfunction

    task automatic model_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wdata, output logic [31:0] e_rd, output logic e_err);
        int idx;
        bit ok;
        idx   = int'((addr >> 2) % DEPTH);
        ok    = ref_legal(be, addr);
        e_err = ALIGN_EN && !ok;
        if (we) begin
            if (ok) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end else begin
            last_rd = ok ? ref_mem[idx] : 32'h0;
        end
        e_rd = last_rd;
    endtask

    // One handshake: drive in IDLE, scramble inputs after acceptance, wait for ack.
    task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata,
                           input logic [31:0] exp_rd, input logic exp_err);
        int   n;
        logic got;
        logic [31:0] rd_seen;
        logic err_seen;
        @(negedge clk);
        req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wdata;
        @(posedge clk);
        @(negedge clk);
        req_i = 1'b0; we_i = ~we; addr_i = $urandom; be_i = 4'($urandom); wdata_i = $urandom;
        n = 1;
        got = 1'b0;
        while (!got && n <= 20) begin
            if (ack_o) got = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        chk({name, " ack_seen"}, 32'(got), 32'd1);
        rd_seen  = rdata_o;
        err_seen = err_o;
        if (got) begin
            chk({name, " latency"}, n, WC + 1);
            chk({name, " err"}, 32'(err_seen), 32'(exp_err));
            chk({name, " rdata"}, rd_seen, exp_rd);
            @(negedge clk);
            chk({name, " ack_one_cycle"}, 32'(ack_o), 32'd0);
            chk({name, " busy_after"}, 32'(busy_o), 32'd0);
            chk({name, " rdata_held"}, rdata_o, exp_rd);
        end
        $display("txn %s we=%0d addr=%h be=%b wdata=%h -> rdata=%h err=%0d lat=%0d",
                 name, we, addr, be, wdata, rd_seen, err_seen, n);
    endtask

    task automatic model_and_run(input string name, input logic we, input logic [31:0] addr,
                                 input logic [3:0] be, input logic [31:0] wdata);
        logic [31:0] e_rd;
        logic        e_err;
        model_txn(we, addr, be, wdata, e_rd, e_err);
        run_txn(name, we, addr, be, wdata, e_rd, e_err);
    endtask

    initial begin
        logic [31:0] e_rd;
        logic        e_err;
        logic        any_ack;

        req_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; be_i = 4'h0; wdata_i = 32'h0;
        rst = 1'b1;
        last_rd = 32'h0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset rdata", rdata_o, 32'h0);
        chk("reset ack", 32'(ack_o), 32'd0);
        chk("reset busy", 32'(busy_o), 32'd0);
        chk("reset err", 32'(err_o), 32'd0);
        $display("txn reset rdata=%h ack=%0d busy=%0d err=%0d", rdata_o, ack_o, busy_o, err_o);
        rst = 1'b0;

        // Give the working window defined contents (RAM is never cleared).
        for (int i = 0; i < 32; i++) begin
            model_and_run("init", 1'b1, 32'(i * 4), 4'hF, $urandom);
        end

        // Directed table: full store/load, byte merge, alias, halfword and byte lanes.
        vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0000_0000, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0010, 4'h1, 32'h0000_00AA, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0000_0000, 32'hDEADBEAA, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_1010, 4'hF, 32'h12345678, 32'hDEADBEAA, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0000_0000, 32'h12345678, 1'b0};
        vecs[6]  = '{1'b1, 32'h0000_0014, 4'hF, 32'h11223344, 32'h12345678, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_0016, 4'hC, 32'hAABB0000, 32'h12345678, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0014, 4'hF, 32'h0000_0000, 32'hAABB3344, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0015, 4'h2, 32'h0000CC00, 32'hAABB3344, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_0014, 4'hF, 32'h0000_0000, 32'hAABBCC44, 1'b0};
        for (int v = 0; v < 11; v++) begin
            model_txn(vecs[v].we, vecs[v].addr, vecs[v].be, vecs[v].wdata, e_rd, e_err);
            run_txn($sformatf("vec%0d", v), vecs[v].we, vecs[v].addr, vecs[v].be,
                    vecs[v].wdata, vecs[v].exp_rd, vecs[v].exp_err);
        end

        // be=0000 store: acked, memory untouched (rejected when alignment checking).
        model_and_run("be0_store", 1'b1, 32'h0000_0010, 4'h0, 32'hFFFFFFFF);
        model_and_run("be0_load", 1'b0, 32'h0000_0010, 4'hF, 32'h0);

        // req_i held high: back-to-back loads, one IDLE cycle per transaction.
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0010; be_i = 4'hF; wdata_i = 32'h0;
        @(posedge clk);
        for (int i = 1; i <= 3 * PER; i++) begin
            @(negedge clk);
            chk($sformatf("held busy c%0d", i), 32'(busy_o), 32'((i % PER) != 0));
            chk($sformatf("held ack c%0d", i), 32'(ack_o), 32'((i % PER) == PER - 1));
            if ((i % PER) == PER - 1) begin
                chk($sformatf("held rdata c%0d", i), rdata_o, ref_mem[4]);
                $display("txn held load addr=00000010 -> rdata=%h ack at cycle %0d", rdata_o, i);
            end
            if (i == 3 * PER) req_i = 1'b0;
        end
        last_rd = ref_mem[4];

        // Reset while a store waits: no write, no ack, outputs cleared.
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0020; be_i = 4'hF; wdata_i = 32'h55555555;
        @(posedge clk);
        @(negedge clk);
        chk("rstwait in_wait busy", 32'(busy_o), 32'd1);
        rst = 1'b1; req_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstwait rdata", rdata_o, 32'h0);
        chk("rstwait ack", 32'(ack_o), 32'd0);
        chk("rstwait busy", 32'(busy_o), 32'd0);
        chk("rstwait err", 32'(err_o), 32'd0);
        rst = 1'b0;
        last_rd = 32'h0;
        any_ack = 1'b0;
        for (int i = 0; i < 2 * PER; i++) begin
            @(negedge clk);
            any_ack = any_ack | ack_o;
        end
        chk("rstwait no_ack", 32'(any_ack), 32'd0);
        $display("txn reset-during-wait store addr=00000020 dropped");
        model_and_run("rstwait_load", 1'b0, 32'h0000_0020, 4'hF, 32'h0);

        // Request coincident with reset is ignored.
        @(negedge clk);
        rst = 1'b1; req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0000_0024; be_i = 4'hF;
        wdata_i = 32'hA5A5A5A5;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; req_i = 1'b0;
        any_ack = busy_o;
        for (int i = 0; i < 2 * PER; i++) begin
            @(negedge clk);
            any_ack = any_ack | ack_o | busy_o;
        end
        chk("rstreq ignored", 32'(any_ack), 32'd0);
        $display("txn req-with-reset store addr=00000024 ignored");
        last_rd = 32'h0;
        model_and_run("rstreq_load", 1'b0, 32'h0000_0024, 4'hF, 32'h0);

        // Misaligned accesses: flagged with the alignment check, plain otherwise.
        model_and_run("mis_store", 1'b1, 32'h0000_0022, 4'hF, 32'hCAFEF00D);
        model_and_run("mis_check", 1'b0, 32'h0000_0020, 4'hF, 32'h0);
        model_and_run("mis_load", 1'b0, 32'h0000_0021, 4'h3, 32'h0);

        // Randomized traffic over a 32-word window with aliasing upper bits.
        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_F000) | 32'(($urandom % 32) * 4) | 32'($urandom % 4);
            model_and_run($sformatf("rnd%0d", t), 1'($urandom % 2), a, 4'($urandom), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
